mem_access_unit: RTL and testbench

//  Load/store front-end between CPU datapath and byte-addressed data RAM (32-bit port,

---
 rtl/mem_access_unit.sv | 159 +++++++++++++++
 tb/tb_mem_access_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front-end between the CPU datapath and a word-wide
// data RAM. Sub-word loads are lane-selected and sign/zero extended; sub-word
// stores are done as an atomic read-modify-write. One access in flight.
// Optional feature macro: MAU_MISALIGN_ERR_EN (reject misaligned/illegal requests).
module mem_access_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_we_i,
    input  logic [2:0]       req_funct3_i,
    input  logic [WIDTH-1:0] req_addr_i,
    input  logic [WIDTH-1:0] req_wdata_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_rdata_o,
    output logic             rsp_err_o,
    output logic [WIDTH-1:0] ram_a_o,
    output logic             ram_we_o,
    output logic [WIDTH-1:0] ram_wd_o,
    input  logic [WIDTH-1:0] ram_rd_i
);

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WRITE,
        S_RESP
    } state_t;

    state_t state;
    state_t state_nx;

    logic             we_q;
    logic [1:0]       size_q;
    logic             uns_q;
    logic [1:0]       off_q;
    logic [WIDTH-1:0] wdata_q;

    logic [1:0]       size_c;
    logic [1:0]       off_c;
    logic             reject_c;
    logic [4:0]       sh_c;
    logic [WIDTH-1:0] lane_c;
    logic [WIDTH-1:0] load_c;
    logic [WIDTH-1:0] mask_c;
    logic [WIDTH-1:0] ins_c;
    logic [WIDTH-1:0] merge_c;

    // Request decode: access size, effective lane offset and rejection
    always_comb begin
        size_c   = (req_funct3_i[1:0] == 2'b11) ? SZ_W : req_funct3_i[1:0];
        off_c    = req_addr_i[1:0];
        reject_c = 1'b0;
        if (size_c == SZ_H) off_c[0] = 1'b0;
        if (size_c == SZ_W) off_c    = 2'b00;
`ifdef MAU_MISALIGN_ERR_EN
        if ((req_funct3_i == 3'b011) || (req_funct3_i == 3'b110) || (req_funct3_i == 3'b111))
            reject_c = 1'b1;
        if (req_we_i && req_funct3_i[2])
            reject_c = 1'b1;
        if ((size_c == SZ_H) && req_addr_i[0])
            reject_c = 1'b1;
        if ((size_c == SZ_W) && (req_addr_i[1:0] != 2'b00))
            reject_c = 1'b1;
`endif
    end

    // Load lane extraction/extension and store read-modify-write merge
    always_comb begin
        sh_c   = {off_q, 3'b000};
        lane_c = ram_rd_i >> sh_c;
        mask_c = '1;
        ins_c  = wdata_q;
        case (size_q)
            SZ_B: begin
                load_c = uns_q ? WIDTH'(lane_c[7:0])
                               : {{(WIDTH-8){lane_c[7]}}, lane_c[7:0]};
                mask_c = WIDTH'(8'hFF) << sh_c;
                ins_c  = WIDTH'(wdata_q[7:0]) << sh_c;
            end
            SZ_H: begin
                load_c = uns_q ? WIDTH'(lane_c[15:0])
                               : {{(WIDTH-16){lane_c[15]}}, lane_c[15:0]};
                mask_c = WIDTH'(16'hFFFF) << sh_c;
                ins_c  = WIDTH'(wdata_q[15:0]) << sh_c;
            end
            default: begin
                load_c = ram_rd_i;
            end
        endcase
        merge_c = (ram_rd_i & ~mask_c) | (ins_c & mask_c);
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (req_valid_i) state_nx = reject_c ? S_RESP : S_ACCESS;
            S_ACCESS: state_nx = we_q ? S_WRITE : S_RESP;
            S_WRITE:  state_nx = S_RESP;
            S_RESP:   if (rsp_ready_i) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Handshake and write strobe decoded straight from the state register
    assign req_ready_o = (state == S_IDLE);
    assign rsp_valid_o = (state == S_RESP);
    assign ram_we_o    = (state == S_WRITE);

    // Request capture, RAM address/data and response registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q        <= 1'b0;
            size_q      <= SZ_B;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
            wdata_q     <= '0;
            ram_a_o     <= '0;
            ram_wd_o    <= '0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        we_q        <= req_we_i;
                        size_q      <= size_c;
                        uns_q       <= req_funct3_i[2];
                        off_q       <= off_c;
                        wdata_q     <= req_wdata_i;
                        ram_a_o     <= {req_addr_i[WIDTH-1:2], 2'b00};
                        rsp_rdata_o <= '0;
                        rsp_err_o   <= reject_c;
                    end
                end
                S_ACCESS: begin
                    if (we_q) ram_wd_o    <= merge_c;
                    else      rsp_rdata_o <= load_c;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: behavioural RAM, reference memory
// model and a scoreboard of expected responses.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] ram_a;
    logic        ram_we;
    logic [31:0] ram_wd;
    logic [31:0] ram_rd;

    mem_access_unit #(.WIDTH(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_funct3_i(req_funct3),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .ram_a_o     (ram_a),
        .ram_we_o    (ram_we),
        .ram_wd_o    (ram_wd),
        .ram_rd_i    (ram_rd)
    );

    always #5 clk = ~clk;

    // Behavioural data RAM: combinational read, whole-word write
    logic [31:0] ram     [16];
    logic [31:0] ref_mem [16];
    assign ram_rd = ram[ram_a[5:2]];
    always @(posedge clk) if (ram_we) ram[ram_a[5:2]] <= ram_wd;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model of one request; updates the reference memory for stores
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wd, output exp_t e);
        int          idx;
        int          o;
        int          sz;
        logic        rej;
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        idx = int'(addr[5:2]);
        w   = ref_mem[idx];
        o   = int'(addr[1:0]);
        sz  = (f3[1:0] == 2'b11) ? 2 : int'(f3[1:0]);
        rej = 1'b0;
`ifdef MAU_MISALIGN_ERR_EN
        rej = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]) ||
              (sz == 1 && addr[0]) || (sz == 2 && o != 0);
`endif
        if (sz == 1) o = o & 2;
        if (sz == 2) o = 0;
        e.err   = rej;
        e.rdata = 32'h0;
        e.lat   = rej ? 1 : (we ? 3 : 2);
        if (!rej) begin
            if (we) begin
                case (sz)
                    0:       w[8*o +: 8]  = wd[7:0];
                    1:       w[8*o +: 16] = wd[15:0];
                    default: w = wd;
                endcase
                ref_mem[idx] = w;
            end else begin
                b = w[8*o +: 8];
                h = w[8*o +: 16];
                case (sz)
                    0:       e.rdata = f3[2] ? {24'h0, b} : {{24{b[7]}}, b};
                    1:       e.rdata = f3[2] ? {16'h0, h} : {{16{h[15]}}, h};
                    default: e.rdata = w;
                endcase
            end
        end
    endfunction

    // One full request/response; optional stall of rsp_ready for 'stall' cycles
    task automatic xfer(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int stall, input string tag);
        exp_t e;
        exp_t g;
        int   lat;
        int   we_cnt;
        bit   seen;
        model(we, f3, addr, wd, e);
        sb_q.push_back(e);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        rsp_ready  = (stall == 0);
        for (int i = 0; i < 20; i++) begin
            if (req_ready) break;
            @(negedge clk);
        end
        check({tag, ":req_ready"}, 32'(req_ready), 32'd1);
        if (!req_ready) begin
            req_valid = 1'b0;
            void'(sb_q.pop_front());
            return;
        end
        @(posedge clk);
        lat    = 0;
        we_cnt = 0;
        seen   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            lat++;
            if (i == 0 && !e.err) check({tag, ":ram_a"}, ram_a, {addr[31:2], 2'b00});
            if (ram_we) we_cnt++;
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, ":rsp_valid"}, 32'(rsp_valid), 32'd1);
        g = sb_q.pop_front();
        if (!seen) return;
        check({tag, ":latency"}, 32'(lat), 32'(g.lat));
        check({tag, ":we_pulses"}, 32'(we_cnt), (we && !g.err) ? 32'd1 : 32'd0);
        if (stall > 0) begin
            // a competing request is presented while the response is held
            req_valid  = 1'b1;
            req_we     = 1'b0;
            req_funct3 = 3'b010;
            req_addr   = 32'h0001_0004;
            for (int k = 0; k < stall; k++) begin
                check({tag, ":hold_valid"}, 32'(rsp_valid), 32'd1);
                check({tag, ":hold_rdata"}, rsp_rdata, g.rdata);
                check({tag, ":hold_ready"}, 32'(req_ready), 32'd0);
                @(negedge clk);
            end
            req_valid = 1'b0;
            rsp_ready = 1'b1;
        end
        check({tag, ":rdata"}, rsp_rdata, g.rdata);
        check({tag, ":err"}, 32'(rsp_err), 32'(g.err));
        @(posedge clk);
        @(negedge clk);
        check({tag, ":ram_word"}, ram[addr[5:2]], ref_mem[addr[5:2]]);
        check({tag, ":idle"}, 32'(req_ready), 32'd1);
    endtask

    // Watchdog so the run always ends
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        w;
        logic [2:0]  f;
        logic [31:0] a;
        bit          wr_seen;

        for (int i = 0; i < 16; i++) begin
            ram[i]     = 32'h0F1E_2D3C ^ (32'(i) * 32'h0103_0507);
            ref_mem[i] = ram[i];
        end
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        rsp_ready  = 1'b1;
        repeat (2) @(negedge clk);
        check("rst:req_ready", 32'(req_ready), 32'd1);
        check("rst:rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst:rsp_rdata", rsp_rdata, 32'h0);
        check("rst:rsp_err",   32'(rsp_err), 32'd0);
        check("rst:ram_we",    32'(ram_we), 32'd0);
        check("rst:ram_a",     ram_a, 32'h0);
        check("rst:ram_wd",    ram_wd, 32'h0);
        rst = 1'b0;

        xfer(1'b1, 3'b010, 32'h0001_0000, 32'h1122_3344, 0, "sw");
        check("sw:word", ram[0], 32'h1122_3344);
        xfer(1'b0, 3'b010, 32'h0001_0000, 32'h0, 0, "lw");
        xfer(1'b1, 3'b000, 32'h0001_0002, 32'h1234_56AA, 0, "sb");
        check("sb:word", ram[0], 32'h11AA_3344);
        xfer(1'b0, 3'b000, 32'h0001_0002, 32'h0, 0, "lb");
        xfer(1'b0, 3'b100, 32'h0001_0002, 32'h0, 0, "lbu");
        xfer(1'b0, 3'b001, 32'h0001_0002, 32'h0, 0, "lh");
        xfer(1'b1, 3'b001, 32'h0001_0001, 32'h0000_BEEF, 0, "sh_odd");
`ifdef MAU_MISALIGN_ERR_EN
        check("sh_odd:word", ram[0], 32'h11AA_3344);
`else
        check("sh_odd:word", ram[0], 32'h11AA_BEEF);
`endif
        xfer(1'b0, 3'b101, 32'h0001_0003, 32'h0, 0, "lhu_odd");
        xfer(1'b0, 3'b010, 32'h0001_0004, 32'h0, 5, "lw_stall");

        for (int n = 0; n < 40; n++) begin
            w = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0:       f = 3'b000;
                1:       f = 3'b001;
                2:       f = 3'b010;
                3:       f = w ? 3'b000 : 3'b100;
                default: f = w ? 3'b001 : 3'b101;
            endcase
`ifdef MAU_MISALIGN_ERR_EN
            if ($urandom_range(0, 7) == 0) f = 3'($urandom_range(3, 7));
`endif
            a = 32'h0001_0000 + 32'($urandom_range(0, 63));
            xfer(w, f, a, $urandom, (n % 8 == 3) ? 2 : 0, "rnd");
        end

        // reset while the SB write strobe is high drops the write
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h0001_0009;
        req_wdata  = 32'h0000_0055;
        rsp_ready  = 1'b1;
        check("rstw:req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        wr_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (ram_we) begin
                wr_seen = 1'b1;
                break;
            end
        end
        check("rstw:we_seen", 32'(wr_seen), 32'd1);
        rst = 1'b1;
        #1;
        check("rstw:ram_we",    32'(ram_we), 32'd0);
        check("rstw:req_ready", 32'(req_ready), 32'd1);
        check("rstw:rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rstw:word", ram[2], ref_mem[2]);
        xfer(1'b0, 3'b010, 32'h0001_0008, 32'h0, 0, "rstw_lw");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
